// File: rtl/m_serial_logic_sched_pkg.sv
// rtl/m_serial_logic_sched_pkg.sv - shared opcodes and FSM encodings for the serial logic scheduler
// Purpose: opcode constants for the shared 1-bit logic cell and the
//          sequencer state encoding used by m_serial_logic_sched.
// Ports:   none (package)
package m_serial_logic_sched_pkg;

   localparam logic [1:0] OP_AND = 2'b00;
   localparam logic [1:0] OP_OR  = 2'b01;
   localparam logic [1:0] OP_XOR = 2'b10;
   localparam logic [1:0] OP_NOT = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_SHIFT = 2'b01,
      ST_DONE  = 2'b10
   } state_t;

endpackage

// File: rtl/m_and.sv
// rtl/m_and.sv - 1-bit AND gate
// Purpose: library 2-input AND.
// Ports:   i_a, i_b - inputs; o_y - i_a & i_b
module m_and (
   input  logic i_a,
   input  logic i_b,
   output logic o_y
);
   assign o_y = i_a & i_b;
endmodule

// File: rtl/m_logic_cell.sv
// rtl/m_logic_cell.sv - combinational 1-bit AND/OR/XOR/NOT unit
// Purpose: the single shared logic cell; evaluates all four gates and
//          selects one by opcode.
// Ports:   i_a, i_b - operand bits; i_op - opcode; o_out - result bit
module m_logic_cell
   import m_serial_logic_sched_pkg::*;
(
   input  logic       i_a,
   input  logic       i_b,
   input  logic [1:0] i_op,
   output logic       o_out
);

   logic and_y;
   logic or_y;
   logic xor_y;
   logic not_y;

   m_and u_and (.i_a(i_a), .i_b(i_b), .o_y(and_y));
   m_or  u_or  (.i_a(i_a), .i_b(i_b), .o_y(or_y));
   m_xor u_xor (.i_a(i_a), .i_b(i_b), .o_y(xor_y));
   m_not u_not (.i_a(i_a), .o_y(not_y));

   always_comb begin
      o_out = 1'b0;
      case (i_op)
         OP_AND:  o_out = and_y;
         OP_OR:   o_out = or_y;
         OP_XOR:  o_out = xor_y;
         OP_NOT:  o_out = not_y;
         default: o_out = 1'b0;
      endcase
   end

endmodule

// File: rtl/m_not.sv
// rtl/m_not.sv - 1-bit inverter
// Purpose: library inverter.
// Ports:   i_a - input; o_y - ~i_a
module m_not (
   input  logic i_a,
   output logic o_y
);
   assign o_y = ~i_a;
endmodule

// File: rtl/m_or.sv
// rtl/m_or.sv - 1-bit OR gate
// Purpose: library 2-input OR.
// Ports:   i_a, i_b - inputs; o_y - i_a | i_b
module m_or (
   input  logic i_a,
   input  logic i_b,
   output logic o_y
);
   assign o_y = i_a | i_b;
endmodule

// File: rtl/m_xor.sv
// rtl/m_xor.sv - 1-bit XOR gate
// Purpose: library 2-input XOR.
// Ports:   i_a, i_b - inputs; o_y - i_a ^ i_b
module m_xor (
   input  logic i_a,
   input  logic i_b,
   output logic o_y
);
   assign o_y = i_a ^ i_b;
endmodule

// File: rtl/m_serial_logic_sched.sv
// rtl/m_serial_logic_sched.sv - two-requester arbiter and bit-serial sequencer for one logic cell
// Purpose: grants one of two requesters, runs its operation LSB first through
//          the shared logic cell over WIDTH cycles, and offers the result on a
//          valid/ready port.
// Ports:   i_clk, i_rst          - clock, async active-high reset
//          i_reqN_valid/op/a/b   - requester N operation
//          o_reqN_ready          - requester N accepted when valid&ready
//          o_res_valid/data/id   - result word and owning requester
//          i_res_ready           - consumer handshake
//          o_busy                - an operation is in flight or awaiting handshake
module m_serial_logic_sched
   import m_serial_logic_sched_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int CNT_W = 5
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_req0_valid,
   input  logic [1:0]       i_req0_op,
   input  logic [WIDTH-1:0] i_req0_a,
   input  logic [WIDTH-1:0] i_req0_b,
   output logic             o_req0_ready,
   input  logic             i_req1_valid,
   input  logic [1:0]       i_req1_op,
   input  logic [WIDTH-1:0] i_req1_a,
   input  logic [WIDTH-1:0] i_req1_b,
   output logic             o_req1_ready,
   output logic             o_res_valid,
   output logic [WIDTH-1:0] o_res_data,
   output logic             o_res_id,
   input  logic             i_res_ready,
   output logic             o_busy
);

   state_t           state;
   state_t           state_nxt;
   logic             prio;       // 0: req0 wins a tie, 1: req1 wins a tie
   logic             gnt_id;
   logic             accept;
   logic             last_bit;
   logic             cell_out;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [1:0]       op_q;
   logic             id_q;
   logic [CNT_W-1:0] cnt;
   logic [WIDTH-1:0] res_sh;
   logic [WIDTH-1:0] res_data;
   logic             res_valid;
   logic             res_id;

   // A lone requester wins outright; only a tie consults the pointer.
   always_comb begin
      gnt_id = 1'b0;
      if (i_req0_valid && i_req1_valid) gnt_id = prio;
      else                              gnt_id = i_req1_valid;
   end

   assign o_req0_ready = (state == ST_IDLE) && i_req0_valid && !gnt_id;
   assign o_req1_ready = (state == ST_IDLE) && i_req1_valid &&  gnt_id;
   assign accept       = o_req0_ready || o_req1_ready;
   assign last_bit     = (cnt == CNT_W'(WIDTH - 1));

   m_logic_cell u_cell (
      .i_a  (a_q[0]),
      .i_b  (b_q[0]),
      .i_op (op_q),
      .o_out(cell_out)
   );

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  if (accept)      state_nxt = ST_SHIFT;
         ST_SHIFT: if (last_bit)    state_nxt = ST_DONE;
         ST_DONE:  if (i_res_ready) state_nxt = ST_IDLE;
         default:                   state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) state <= ST_IDLE;
      else       state <= state_nxt;
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         prio      <= 1'b0;
         a_q       <= '0;
         b_q       <= '0;
         op_q      <= OP_AND;
         id_q      <= 1'b0;
         cnt       <= '0;
         res_sh    <= '0;
         res_data  <= '0;
         res_valid <= 1'b0;
         res_id    <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  a_q  <= gnt_id ? i_req1_a  : i_req0_a;
                  b_q  <= gnt_id ? i_req1_b  : i_req0_b;
                  op_q <= gnt_id ? i_req1_op : i_req0_op;
                  id_q <= gnt_id;
                  cnt  <= '0;
                  prio <= ~gnt_id;
               end
            end
            ST_SHIFT: begin
               // Bits enter at the MSB so after WIDTH shifts bit 0 sits at LSB.
               res_sh <= {cell_out, res_sh[WIDTH-1:1]};
               a_q    <= a_q >> 1;
               b_q    <= b_q >> 1;
               cnt    <= cnt + CNT_W'(1);
               // The visible word only changes on completion, so it holds
               // the previous result while the next one is being built.
               if (last_bit) begin
                  res_data  <= {cell_out, res_sh[WIDTH-1:1]};
                  res_id    <= id_q;
                  res_valid <= 1'b1;
               end
            end
            ST_DONE: begin
               if (i_res_ready) res_valid <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   assign o_res_valid = res_valid;
   assign o_res_data  = res_data;
   assign o_res_id    = res_id;
   assign o_busy      = (state != ST_IDLE);

endmodule
